// File: rtl/fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_pkg
// Shared definitions for the UART byte-FIFO sequencing controller.
//   - state_e : controller FSM state encoding (IDLE / LOAD / READ)
//   - grant_e : arbiter grant identifiers (write side / read side)
//   - default sizing for the FIFO depth, counter width and done timeout
//   - other_side() : helper returning the opposite requester
// -----------------------------------------------------------------------------
package fifo_ctrl_pkg;

    localparam int DEPTH_DEF   = 8;
    localparam int CNT_W_DEF   = 4;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2
    } state_e;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_e;

    function automatic grant_e other_side(input grant_e g);
        return (g == GNT_WR) ? GNT_RD : GNT_WR;
    endfunction

endpackage

// File: rtl/fifo_ctrl_arb.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_arb
// Two-way round-robin arbiter between the write and read requesters.
// Purely combinational; the caller owns and updates last_grant.
//
// Ports:
//   wr_ok      in   write side is eligible this cycle
//   rd_ok      in   read side is eligible this cycle
//   last_grant in   side granted most recently
//   gnt_vld    out  some side is granted
//   gnt        out  which side is granted (meaningful when gnt_vld)
// -----------------------------------------------------------------------------
module fifo_ctrl_arb
    import fifo_ctrl_pkg::*;
(
    input  logic   wr_ok,
    input  logic   rd_ok,
    input  grant_e last_grant,
    output logic   gnt_vld,
    output grant_e gnt
);

    always_comb begin
        gnt_vld = wr_ok | rd_ok;
        gnt     = GNT_WR;
        if (wr_ok && rd_ok) begin
            // Tie: the side that was not served last time wins.
            gnt = other_side(last_grant);
        end else if (rd_ok) begin
            gnt = GNT_RD;
        end else begin
            gnt = GNT_WR;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
// Sequencing controller / arbiter in front of the 8-byte UART byte FIFO.
// A write requester pushes bytes and a read requester pulls bytes; this block
// grants one of them at a time, drives the FIFO load/read strobes, waits for
// the matching done handshake, tracks occupancy and aborts a transaction
// whose done never arrives within TIMEOUT cycles. All outputs are registered.
//
// Optional feature (macro FIFO_CTRL_STATUS_EN): adds sticky overflow /
// underflow status flags and a status_clr input.
//
// Ports:
//   clk_fifo_i       in   clock, rising edge
//   reset            in   synchronous active-high reset
//   wr_req/wr_data   in   write request and byte (held until wr_ack)
//   wr_ack           out  one-cycle pulse: byte accepted
//   rd_req           in   read request (held until rd_valid)
//   rd_data          out  last popped byte
//   rd_valid         out  one-cycle pulse: rd_data updated
//   fifo_load        out  FIFO load strobe
//   fifo_data_in     out  byte presented to FIFO
//   LD_fifo_done     in   FIFO load complete
//   fifo_read        out  FIFO read strobe
//   fifo_data_out    in   byte from FIFO
//   RD_fifo_done     in   FIFO read complete
//   count            out  occupancy 0..DEPTH
//   full / empty     out  count == DEPTH / count == 0
//   timeout_err      out  one-cycle pulse on aborted transaction
//   overflow_sticky  out  (FIFO_CTRL_STATUS_EN) write request seen while full
//   underflow_sticky out  (FIFO_CTRL_STATUS_EN) read request seen while empty
//   status_clr       in   (FIFO_CTRL_STATUS_EN) clears both sticky flags
// -----------------------------------------------------------------------------
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk_fifo_i,
    input  logic             reset,
    input  logic             wr_req,
    input  logic [7:0]       wr_data,
    output logic             wr_ack,
    input  logic             rd_req,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             fifo_load,
    output logic [7:0]       fifo_data_in,
    input  logic             LD_fifo_done,
    output logic             fifo_read,
    input  logic [7:0]       fifo_data_out,
    input  logic             RD_fifo_done,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             timeout_err
`ifdef FIFO_CTRL_STATUS_EN
    ,
    output logic             overflow_sticky,
    output logic             underflow_sticky,
    input  logic             status_clr
`endif
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

    // FSM state and arbitration history
    state_e            state;
    state_e            state_nxt;
    grant_e            last_grant;
    grant_e            last_grant_nxt;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_nxt;

    // Transaction outcome decoded from the current state
    logic              wr_done;
    logic              rd_done;
    logic              abort;

    // Arbitration
    logic              settle;
    logic              wr_ok;
    logic              rd_ok;
    logic              gnt_vld;
    grant_e            gnt;

    // Next values of the registered outputs
    logic              fifo_load_nxt;
    logic              fifo_read_nxt;
    logic [7:0]        fifo_data_in_nxt;
    logic              wr_ack_nxt;
    logic              rd_valid_nxt;
    logic [7:0]        rd_data_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              full_nxt;
    logic              empty_nxt;
    logic              timeout_err_nxt;

    // The cycle right after a completion or abort is the requester's chance to
    // see ack/valid and drop (or renew) its request. Granting in that cycle
    // would re-serve a request that was already satisfied, so every IDLE stint
    // lasts at least this one settle cycle.
    assign settle = wr_ack | rd_valid | timeout_err;
    assign wr_ok  = wr_req & ~full  & ~settle;
    assign rd_ok  = rd_req & ~empty & ~settle;

    fifo_ctrl_arb u_arb (
        .wr_ok      (wr_ok),
        .rd_ok      (rd_ok),
        .last_grant (last_grant),
        .gnt_vld    (gnt_vld),
        .gnt        (gnt)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        wr_done        = 1'b0;
        rd_done        = 1'b0;
        abort          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_nxt      = (gnt == GNT_WR) ? ST_LOAD : ST_READ;
                    last_grant_nxt = gnt;
                end
            end
            ST_LOAD: begin
                // RD_fifo_done is deliberately not looked at here.
                if (LD_fifo_done) begin
                    state_nxt = ST_IDLE;
                    wr_done   = 1'b1;
                end else if (timer == TMR_LAST) begin
                    state_nxt = ST_IDLE;
                    abort     = 1'b1;
                end
            end
            ST_READ: begin
                if (RD_fifo_done) begin
                    state_nxt = ST_IDLE;
                    rd_done   = 1'b1;
                end else if (timer == TMR_LAST) begin
                    state_nxt = ST_IDLE;
                    abort     = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic (next values of the registered outputs)
    // -------------------------------------------------------------------------
    always_comb begin
        fifo_load_nxt    = (state_nxt == ST_LOAD);
        fifo_read_nxt    = (state_nxt == ST_READ);
        wr_ack_nxt       = wr_done;
        rd_valid_nxt     = rd_done;
        timeout_err_nxt  = abort;
        fifo_data_in_nxt = fifo_data_in;
        rd_data_nxt      = rd_data;
        count_nxt        = count;

        // Write byte is latched on the granting edge and held through LOAD.
        if (state == ST_IDLE && gnt_vld && gnt == GNT_WR) begin
            fifo_data_in_nxt = wr_data;
        end
        if (rd_done) begin
            rd_data_nxt = fifo_data_out;
        end

        // Eligibility already keeps count in range; the bounds here only
        // make the counter safe on its own.
        if (wr_done && count != CNT_MAX) begin
            count_nxt = count + CNT_W'(1);
        end else if (rd_done && count != '0) begin
            count_nxt = count - CNT_W'(1);
        end
        full_nxt  = (count_nxt == CNT_MAX);
        empty_nxt = (count_nxt == '0);

        // Timer restarts on entry to LOAD/READ and counts while staying there.
        if (state != ST_IDLE && state_nxt == state) begin
            timer_nxt = timer + TMR_W'(1);
        end else begin
            timer_nxt = '0;
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_fifo_i) begin
        if (reset) begin
            state        <= ST_IDLE;
            last_grant   <= GNT_RD;
            timer        <= '0;
            fifo_load    <= 1'b0;
            fifo_read    <= 1'b0;
            fifo_data_in <= '0;
            wr_ack       <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_grant   <= last_grant_nxt;
            timer        <= timer_nxt;
            fifo_load    <= fifo_load_nxt;
            fifo_read    <= fifo_read_nxt;
            fifo_data_in <= fifo_data_in_nxt;
            wr_ack       <= wr_ack_nxt;
            rd_valid     <= rd_valid_nxt;
            rd_data      <= rd_data_nxt;
            count        <= count_nxt;
            full         <= full_nxt;
            empty        <= empty_nxt;
            timeout_err  <= timeout_err_nxt;
        end
    end

`ifdef FIFO_CTRL_STATUS_EN
    // Requests are judged only in a non-settle IDLE cycle, so a requester that
    // is still holding its request while its own ack makes the FIFO full (or
    // its valid makes it empty) does not count as an overflow/underflow.
    logic ovf_set;
    logic unf_set;

    assign ovf_set = (state == ST_IDLE) & ~settle & wr_req & full;
    assign unf_set = (state == ST_IDLE) & ~settle & rd_req & empty;

    always_ff @(posedge clk_fifo_i) begin
        if (reset || status_clr) begin
            overflow_sticky  <= 1'b0;
            underflow_sticky <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow_sticky <= 1'b1;
            end
            if (unf_set) begin
                underflow_sticky <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl
// Self-checking bench for fifo_ctrl. A behavioural byte-FIFO device answers the
// load/read strobes; a reference queue tracks what the FIFO should contain.
// Build with +define+FIFO_CTRL_STATUS_EN to also cover the sticky flags.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 15;

    logic             clk_fifo_i = 1'b0;
    logic             reset;
    logic             wr_req;
    logic [7:0]       wr_data;
    logic             wr_ack;
    logic             rd_req;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             fifo_load;
    logic [7:0]       fifo_data_in;
    logic             LD_fifo_done;
    logic             fifo_read;
    logic [7:0]       fifo_data_out;
    logic             RD_fifo_done;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             timeout_err;
`ifdef FIFO_CTRL_STATUS_EN
    logic             overflow_sticky;
    logic             underflow_sticky;
    logic             status_clr;
`endif

    fifo_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_fifo_i    (clk_fifo_i),
        .reset         (reset),
        .wr_req        (wr_req),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .rd_req        (rd_req),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .fifo_load     (fifo_load),
        .fifo_data_in  (fifo_data_in),
        .LD_fifo_done  (LD_fifo_done),
        .fifo_read     (fifo_read),
        .fifo_data_out (fifo_data_out),
        .RD_fifo_done  (RD_fifo_done),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .timeout_err   (timeout_err)
`ifdef FIFO_CTRL_STATUS_EN
        ,
        .overflow_sticky  (overflow_sticky),
        .underflow_sticky (underflow_sticky),
        .status_clr       (status_clr)
`endif
    );

    always #5 clk_fifo_i = ~clk_fifo_i;

    // ---------------- FIFO device model ----------------
    logic [7:0] mem[$];
    logic [7:0] last_loaded;
    int         ld_lat, rd_lat, ld_wait, rd_wait;
    bit         ld_en, rd_en;

    always @(posedge clk_fifo_i) begin
        LD_fifo_done <= 1'b0;
        RD_fifo_done <= 1'b0;
        if (reset) begin
            mem.delete();
            ld_wait <= 0;
            rd_wait <= 0;
        end else begin
            if (fifo_load && ld_en && !LD_fifo_done) begin
                if (ld_wait >= ld_lat) begin
                    LD_fifo_done <= 1'b1;
                    last_loaded  <= fifo_data_in;
                    mem.push_back(fifo_data_in);
                    ld_wait      <= 0;
                end else begin
                    ld_wait <= ld_wait + 1;
                end
            end else begin
                ld_wait <= 0;
            end
            if (fifo_read && rd_en && !RD_fifo_done) begin
                if (rd_wait >= rd_lat) begin
                    RD_fifo_done <= 1'b1;
                    if (mem.size() > 0) fifo_data_out <= mem.pop_front();
                    else                fifo_data_out <= 8'hEE;
                    rd_wait <= 0;
                end else begin
                    rd_wait <= rd_wait + 1;
                end
            end else begin
                rd_wait <= 0;
            end
        end
    end

    // ---------------- event monitor ----------------
    int n_ack, n_vld, n_load, n_read, n_tmo;
    always @(posedge clk_fifo_i) begin
        if (wr_ack)      n_ack  <= n_ack + 1;
        if (rd_valid)    n_vld  <= n_vld + 1;
        if (fifo_load)   n_load <= n_load + 1;
        if (fifo_read)   n_read <= n_read + 1;
        if (timeout_err) n_tmo  <= n_tmo + 1;
    end

    // ---------------- reference model & checking ----------------
    logic [7:0] ref_q[$];
    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_occupancy(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(ref_q.size()));
        chk({tag, "_full"},  32'(full),  32'(ref_q.size() == DEPTH));
        chk({tag, "_empty"}, 32'(empty), 32'(ref_q.size() == 0));
    endtask

    task automatic do_write(input logic [7:0] b, input string tag);
        bit got = 0;
        wr_data = b;
        wr_req  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_fifo_i);
            if (i == 0) begin
                chk({tag, "_load_strobe"}, 32'(fifo_load), 32'(1));
                chk({tag, "_data_in"}, 32'(fifo_data_in), 32'(b));
            end
            if (wr_ack) begin
                got = 1;
                break;
            end
        end
        wr_req = 1'b0;
        chk({tag, "_ack"}, 32'(got), 32'(1));
        if (got) begin
            ref_q.push_back(b);
            chk({tag, "_stored"}, 32'(last_loaded), 32'(b));
        end
        @(negedge clk_fifo_i);
        chk({tag, "_ack_pulse"}, 32'(wr_ack), 32'(0));
        chk_occupancy(tag);
    endtask

    task automatic do_read(input string tag);
        bit got = 0;
        logic [7:0] exp_b;
        rd_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_fifo_i);
            if (i == 0) chk({tag, "_read_strobe"}, 32'(fifo_read), 32'(1));
            if (rd_valid) begin
                got = 1;
                break;
            end
        end
        rd_req = 1'b0;
        chk({tag, "_valid"}, 32'(got), 32'(1));
        if (got) begin
            exp_b = ref_q.pop_front();
            chk({tag, "_data"}, 32'(rd_data), 32'(exp_b));
        end
        @(negedge clk_fifo_i);
        chk({tag, "_valid_pulse"}, 32'(rd_valid), 32'(0));
        chk_occupancy(tag);
    endtask

    initial begin
        int a0, l0, r0, t0, v0;
        int ev[$];
        bit seen;

        reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = 8'h00;
        ld_en = 1; rd_en = 1; ld_lat = 0; rd_lat = 0;
        fifo_data_out = 8'h00;
`ifdef FIFO_CTRL_STATUS_EN
        status_clr = 1'b0;
`endif
        repeat (3) @(negedge clk_fifo_i);
        reset = 1'b0;
        @(negedge clk_fifo_i);

        // Reset state
        chk("rst_fifo_load",   32'(fifo_load),    32'(0));
        chk("rst_fifo_read",   32'(fifo_read),    32'(0));
        chk("rst_wr_ack",      32'(wr_ack),       32'(0));
        chk("rst_rd_valid",    32'(rd_valid),     32'(0));
        chk("rst_rd_data",     32'(rd_data),      32'(0));
        chk("rst_data_in",     32'(fifo_data_in), 32'(0));
        chk("rst_timeout_err", 32'(timeout_err),  32'(0));
        chk_occupancy("rst");
`ifdef FIFO_CTRL_STATUS_EN
        chk("rst_ovf", 32'(overflow_sticky),  32'(0));
        chk("rst_unf", 32'(underflow_sticky), 32'(0));
`endif

        // Single write of A5, then read it back
        a0 = n_ack;
        do_write(8'hA5, "wr_a5");
        chk("wr_a5_one_ack", 32'(n_ack - a0), 32'(1));
        do_read("rd_a5");

        // Randomised mix of writes and reads with random done latency
        for (int k = 0; k < 40; k++) begin
            ld_lat = int'($urandom_range(0, 3));
            rd_lat = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0 && ref_q.size() < DEPTH)
                do_write(8'($urandom), "rnd_wr");
            else if (ref_q.size() > 0)
                do_read("rnd_rd");
        end
        while (ref_q.size() > 0) do_read("drain");
        ld_lat = 0; rd_lat = 0;

        // Fill to full with 01..08
        for (int k = 1; k <= DEPTH; k++) do_write(8'(k), "fill");
        chk("fill_full", 32'(full), 32'(1));
`ifdef FIFO_CTRL_STATUS_EN
        chk("fill_no_ovf", 32'(overflow_sticky), 32'(0));
`endif
        // Ninth write must not be issued
        l0 = n_load; a0 = n_ack;
        wr_data = 8'h09; wr_req = 1'b1;
        repeat (20) @(negedge clk_fifo_i);
        wr_req = 1'b0;
        chk("ninth_no_load", 32'(n_load - l0), 32'(0));
        chk("ninth_no_ack",  32'(n_ack - a0),  32'(0));
        chk_occupancy("ninth");
`ifdef FIFO_CTRL_STATUS_EN
        chk("ninth_ovf", 32'(overflow_sticky), 32'(1));
        status_clr = 1'b1;
        @(negedge clk_fifo_i);
        status_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow_sticky), 32'(0));
`endif

        // Drain all eight in order
        for (int k = 0; k < DEPTH; k++) do_read("empty_out");
        chk("drained_empty", 32'(empty), 32'(1));
`ifdef FIFO_CTRL_STATUS_EN
        chk("drain_no_unf", 32'(underflow_sticky), 32'(0));
`endif
        r0 = n_read;
        rd_req = 1'b1;
        repeat (20) @(negedge clk_fifo_i);
        rd_req = 1'b0;
        chk("empty_no_read", 32'(n_read - r0), 32'(0));
`ifdef FIFO_CTRL_STATUS_EN
        chk("empty_unf", 32'(underflow_sticky), 32'(1));
`endif

        // Count 3, both sides held: grants must alternate
        for (int k = 0; k < 3; k++) do_write(8'($urandom), "pre3");
        wr_data = 8'($urandom);
        wr_req = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 200 && ev.size() < 4; i++) begin
            @(negedge clk_fifo_i);
            if (wr_ack) begin
                ev.push_back(0);
                ref_q.push_back(wr_data);
                wr_data = 8'($urandom);
            end
            if (rd_valid) begin
                ev.push_back(1);
                chk("alt_rd_data", 32'(rd_data), 32'(ref_q.pop_front()));
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        chk("alt_events", 32'(ev.size()), 32'(4));
        for (int i = 1; i < ev.size(); i++)
            chk("alt_order", 32'(ev[i] != ev[i-1]), 32'(1));
        @(negedge clk_fifo_i);
        chk("alt_count3", 32'(count), 32'(3));
        chk_occupancy("alt");

        // Load done never arrives: abort after TIMEOUT strobe cycles
        ld_en = 0;
        l0 = n_load; a0 = n_ack; t0 = n_tmo;
        seen = 0;
        wr_data = 8'h5A; wr_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_fifo_i);
            if (timeout_err) begin
                seen = 1;
                break;
            end
        end
        wr_req = 1'b0;
        repeat (3) @(negedge clk_fifo_i);
        chk("tmo_seen",       32'(seen),          32'(1));
        chk("tmo_load_cycles", 32'(n_load - l0),  32'(TIMEOUT));
        chk("tmo_one_pulse",  32'(n_tmo - t0),    32'(1));
        chk("tmo_no_ack",     32'(n_ack - a0),    32'(0));
        chk_occupancy("tmo");
        ld_en = 1;

        // Reset while a read strobe is high
        rd_en = 0;
        v0 = n_vld;
        seen = 0;
        rd_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_fifo_i);
            if (fifo_read) begin
                seen = 1;
                break;
            end
        end
        chk("rst_mid_read_started", 32'(seen), 32'(1));
        reset = 1'b1; rd_req = 1'b0;
        ref_q.delete();
        @(negedge clk_fifo_i);
        chk("rst_mid_read_strobe", 32'(fifo_read), 32'(0));
        chk_occupancy("rst_mid");
        reset = 1'b0;
        repeat (3) @(negedge clk_fifo_i);
        chk("rst_mid_no_valid", 32'(n_vld - v0), 32'(0));
        rd_en = 1;

        // Controller still works after the mid-transaction reset
        do_write(8'h3C, "post_rst_wr");
        do_read("post_rst_rd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Sequencing controller and arbiter in front of the 8-byte UART byte FIFO.
- Two requesters share the FIFO: a write side (host/RX path pushing bytes) and a read side (TX path pulling bytes).
- Drives the FIFO's load/read strobes, waits for its LD/RD done handshakes and tracks occupancy.
- Reports full/empty and aborts any transaction whose done strobe never arrives.

Parameters:
- DEPTH, 8, FIFO capacity in bytes; count saturates here.
- CNT_W, 4, width of occupancy counter; must hold 0..DEPTH.
- TIMEOUT, 15, max cycles to wait for LD_fifo_done/RD_fifo_done before abort.

Ports:
- clk_fifo_i  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_req  in  1  write requester wants to push wr_data; held until wr_ack.
- wr_data  in  8  byte to push; stable while wr_req high.
- wr_ack  out  1  one-cycle pulse: byte accepted by FIFO.
- rd_req  in  1  read requester wants a byte; held until rd_valid.
- rd_data  out  8  popped byte; valid when rd_valid, held until next pop.
- rd_valid  out  1  one-cycle pulse: rd_data updated.
- fifo_load  out  1  load strobe to FIFO.
- fifo_data_in  out  8  byte presented to FIFO.
- LD_fifo_done  in  1  FIFO load complete.
- fifo_read  out  1  read strobe to FIFO.
- fifo_data_out  in  8  byte from FIFO.
- RD_fifo_done  in  1  FIFO read complete.
- count  out  CNT_W  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- timeout_err  out  1  one-cycle pulse on aborted transaction.

Behaviour:
- Reset values:
  - all outputs 0, except empty=1.
  - State IDLE, last_grant=READ (write wins first tie), timer 0.
- FSM states:
  - IDLE: no strobes.
  - LOAD: fifo_load=1, fifo_data_in = latched wr_data.
  - READ: fifo_read=1.
  - All outputs registered.
- Eligibility in IDLE:
  - wr_ok = wr_req & !full.
  - rd_ok = rd_req & !empty.
  - Only wr_ok → LOAD; only rd_ok → READ.
  - Both → grant the side opposite last_grant, then update last_grant.
  - Neither → stay IDLE.
- Write timing:
  - wr_req sampled in IDLE at cycle N → fifo_load=1 from N+1; wr_data latched at that same edge.
  - First cycle in LOAD with LD_fifo_done=1 → next edge: fifo_load=0, wr_ack=1 for one cycle, count+1, state IDLE.
- Read timing:
  - Same structure as write.
  - On RD_fifo_done, fifo_data_out is captured into rd_data; rd_valid=1 for one cycle; count-1; state IDLE.
- After every completed transaction the FSM spends at least 1 cycle in IDLE before the next grant.
- Back-to-back rate: 1 byte per 3 cycles when done returns in the first strobe cycle.
- Timer clears on entry to LOAD/READ and increments each cycle there.
- Timeout: timer reaches TIMEOUT without done → strobe drops, timeout_err pulses, count unchanged, no ack/valid, state IDLE. Requester may retry.
- Requester dropping its req mid-transaction: ignored; the transaction completes and ack/valid still pulses.
- wr_req while full / rd_req while empty: not granted; no strobe issued; request waits.
- count never exceeds DEPTH or goes below 0 (guarded by eligibility).
- full/empty update in the same cycle as count.
- Done strobes arriving in IDLE, or the wrong done in a state, are ignored.
- reset mid-transaction: strobes drop on the next edge; count clears to 0 (FIFO pointers also reset).

Optional Feature:
- FIFO_CTRL_STATUS_EN defined:
  - Adds output ports overflow_sticky and underflow_sticky, plus input status_clr.
  - overflow_sticky sets when wr_req is seen while full in IDLE; underflow_sticky sets when rd_req is seen while empty in IDLE.
  - Both stay set until status_clr=1 or reset; clear takes priority over set in the same cycle.
- Undefined: these ports and their logic are absent; all other behaviour identical.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_LOAD=2'd1, ST_READ=2'd2), grant constants (GNT_WR, GNT_RD), default DEPTH=8 and TIMEOUT=15.
- One natural sub-module, fifo_ctrl_arb: 2-way round-robin grant from wr_ok, rd_ok and last_grant. The FSM, timer and counter remain in fifo_ctrl.

Test Plan:
- Reset, then wr_req with wr_data=8'hA5; FIFO model returns LD_fifo_done 1 cycle after fifo_load → fifo_data_in=A5, one wr_ack pulse, count=1, empty=0.
- 8 writes (8'h01..8'h08), then a 9th wr_req → full=1 after the 8th; no fifo_load for the 9th. With FIFO_CTRL_STATUS_EN, overflow_sticky=1.
- From count=8, rd_req held → 8 rd_valid pulses with rd_data 01..08 in order, count reaching 0, empty=1; a further rd_req issues no fifo_read.
- count=3, wr_req and rd_req asserted together and held → grants strictly alternate W,R,W,R; count returns to 3 after 4 transactions.
- wr_req with LD_fifo_done tied 0 → fifo_load high for exactly 15 cycles, timeout_err pulses once, count unchanged, no wr_ack.
- reset asserted while fifo_read is high → next cycle fifo_read=0, count=0, empty=1, no rd_valid.
